// File: rtl/uart_lite_fifo.sv
// uart_lite_fifo: UART with a valid/ready transmitter and a show-ahead receive FIFO.
//   Optional feature macro: UART_PARITY_EN (parity bit generation/check; default off).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   div_i                             clocks per bit, latched at each frame start
//   parity_en_i, parity_odd_i         parity enable / odd select (UART_PARITY_EN only)
//   two_stop_i                        TX sends two stop bits
//   tx_valid_i, tx_data_i             TX word offer
//   tx_ready_o, tx_busy_o, tx_o       TX handshake, busy, serial out (idle high)
//   rx_i                              asynchronous serial in
//   rx_valid_o, rx_ready_i            RX FIFO head valid / pop
//   rx_data_o, rx_frame_err_o,
//   rx_parity_err_o                   RX FIFO head word and its flags
//   rx_overrun_o, rx_ovr_clr_i        sticky drop flag and its clear
//   rx_count_o                        RX FIFO occupancy
module uart_lite_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIV_W-1:0]          div_i,
    input  logic                      parity_en_i,
    input  logic                      parity_odd_i,
    input  logic                      two_stop_i,
    input  logic                      tx_valid_i,
    input  logic [DATA_W-1:0]         tx_data_i,
    output logic                      tx_ready_o,
    output logic                      tx_busy_o,
    output logic                      tx_o,
    input  logic                      rx_i,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic [DATA_W-1:0]         rx_data_o,
    output logic                      rx_frame_err_o,
    output logic                      rx_parity_err_o,
    output logic                      rx_overrun_o,
    input  logic                      rx_ovr_clr_i,
    output logic [$clog2(RX_DEPTH):0] rx_count_o
);

    localparam int unsigned PTR_W = $clog2(RX_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    typedef struct packed {
        logic              frame_err;
`ifdef UART_PARITY_EN
        logic              parity_err;
`endif
        logic [DATA_W-1:0] data;
    } rx_word_t;

    // ---------------- TX ----------------
    state_t             r_tx_state;
    logic [DIV_W-1:0]   r_tx_div, r_tx_cnt;
    logic [DATA_W-1:0]  r_tx_shift;
    logic [BIT_W-1:0]   r_tx_bit;
    logic               r_tx_two_stop, r_tx_stop2, r_tx_out, r_tx_ready;
    logic [DIV_W-1:0]   w_tx_last;
`ifdef UART_PARITY_EN
    logic               r_tx_par, r_tx_par_en;
`else
    logic               w_unused_par;
    assign w_unused_par = parity_en_i ^ parity_odd_i;
`endif

    assign w_tx_last = r_tx_div - DIV_W'(1);

    // TX frame sequencer; tx_o is registered so reset forces it high asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state    <= S_IDLE;
            r_tx_div      <= '0;
            r_tx_cnt      <= '0;
            r_tx_shift    <= '0;
            r_tx_bit      <= '0;
            r_tx_two_stop <= 1'b0;
            r_tx_stop2    <= 1'b0;
            r_tx_out      <= 1'b1;
            r_tx_ready    <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par      <= 1'b0;
            r_tx_par_en   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (tx_valid_i) begin
                        r_tx_shift    <= tx_data_i;
                        r_tx_div      <= div_i;
                        r_tx_cnt      <= '0;
                        r_tx_bit      <= '0;
                        r_tx_two_stop <= two_stop_i;
                        r_tx_stop2    <= 1'b0;
                        r_tx_out      <= 1'b0;
                        r_tx_ready    <= 1'b0;
                        r_tx_state    <= S_START;
`ifdef UART_PARITY_EN
                        r_tx_par      <= (^tx_data_i) ^ parity_odd_i;
                        r_tx_par_en   <= parity_en_i;
`endif
                    end
                end
                default: begin
                    if (r_tx_cnt != w_tx_last) begin
                        r_tx_cnt <= r_tx_cnt + DIV_W'(1);
                    end else begin
                        r_tx_cnt <= '0;
                        case (r_tx_state)
                            S_START: begin
                                r_tx_state <= S_DATA;
                                r_tx_out   <= r_tx_shift[0];
                            end
                            S_DATA: begin
                                if (r_tx_bit == BIT_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                                    if (r_tx_par_en) begin
                                        r_tx_state <= S_PARITY;
                                        r_tx_out   <= r_tx_par;
                                    end else begin
                                        r_tx_state <= S_STOP;
                                        r_tx_out   <= 1'b1;
                                    end
`else
                                    r_tx_state <= S_STOP;
                                    r_tx_out   <= 1'b1;
`endif
                                end else begin
                                    r_tx_bit   <= r_tx_bit + BIT_W'(1);
                                    r_tx_shift <= r_tx_shift >> 1;
                                    r_tx_out   <= r_tx_shift[1];
                                end
                            end
`ifdef UART_PARITY_EN
                            S_PARITY: begin
                                r_tx_state <= S_STOP;
                                r_tx_out   <= 1'b1;
                            end
`endif
                            S_STOP: begin
                                if (r_tx_two_stop && !r_tx_stop2) begin
                                    r_tx_stop2 <= 1'b1;
                                end else begin
                                    r_tx_state <= S_IDLE;
                                    r_tx_ready <= 1'b1;
                                end
                            end
                            default: r_tx_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx_o       = r_tx_out;
    assign tx_ready_o = r_tx_ready;
    assign tx_busy_o  = ~r_tx_ready;

    // ---------------- RX ----------------
    logic               r_rx_sync1, r_rx_sync2, r_rx_prev;
    state_t             r_rx_state;
    logic [DIV_W-1:0]   r_rx_div, r_rx_cnt;
    logic [DATA_W-1:0]  r_rx_shift;
    logic [BIT_W-1:0]   r_rx_bit;
    logic               w_rx_fall, w_rx_mid, w_rx_end, w_push;
`ifdef UART_PARITY_EN
    logic               r_rx_par_en, r_rx_par_odd, r_rx_par_err;
`endif

    // Two-flop synchroniser plus one flop for falling-edge detection; idle line is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= rx_i;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync2;
    assign w_rx_mid  = (r_rx_cnt == ((r_rx_div >> 1) - DIV_W'(1)));
    assign w_rx_end  = (r_rx_cnt == (r_rx_div - DIV_W'(1)));
    assign w_push    = (r_rx_state == S_STOP) && w_rx_mid;

    // RX frame sequencer; leaves STOP at the mid-bit sample to allow early resync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state   <= S_IDLE;
            r_rx_div     <= '0;
            r_rx_cnt     <= '0;
            r_rx_shift   <= '0;
            r_rx_bit     <= '0;
`ifdef UART_PARITY_EN
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
            r_rx_par_err <= 1'b0;
`endif
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state   <= S_START;
                        r_rx_div     <= div_i;
                        r_rx_cnt     <= '0;
                        r_rx_bit     <= '0;
`ifdef UART_PARITY_EN
                        r_rx_par_en  <= parity_en_i;
                        r_rx_par_odd <= parity_odd_i;
                        r_rx_par_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_rx_cnt <= w_rx_end ? '0 : r_rx_cnt + DIV_W'(1);
                    case (r_rx_state)
                        S_START: begin
                            if (w_rx_mid && r_rx_sync2) begin
                                r_rx_state <= S_IDLE;
                                r_rx_cnt   <= '0;
                            end else if (w_rx_end) begin
                                r_rx_state <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (w_rx_mid) begin
                                r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_W-1:1]};
                            end
                            if (w_rx_end) begin
                                if (r_rx_bit == BIT_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                                    r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
`else
                                    r_rx_state <= S_STOP;
`endif
                                end else begin
                                    r_rx_bit <= r_rx_bit + BIT_W'(1);
                                end
                            end
                        end
`ifdef UART_PARITY_EN
                        S_PARITY: begin
                            if (w_rx_mid) begin
                                r_rx_par_err <= r_rx_sync2 ^ (^r_rx_shift) ^ r_rx_par_odd;
                            end
                            if (w_rx_end) begin
                                r_rx_state <= S_STOP;
                            end
                        end
`endif
                        S_STOP: begin
                            if (w_rx_mid) begin
                                r_rx_state <= S_IDLE;
                                r_rx_cnt   <= '0;
                            end
                        end
                        default: r_rx_state <= S_IDLE;
                    endcase
                end
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    rx_word_t           r_mem [RX_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovr;
    rx_word_t           w_push_word, w_head;
    logic               w_full, w_pop, w_wr;

    always_comb begin
        w_push_word           = '0;
        w_push_word.data      = r_rx_shift;
        w_push_word.frame_err = ~r_rx_sync2;
`ifdef UART_PARITY_EN
        w_push_word.parity_err = r_rx_par_err;
`endif
    end

    assign w_full = (r_count == CNT_W'(RX_DEPTH));
    assign w_pop  = (r_count != '0) && rx_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (w_push && !w_wr) begin
                r_ovr <= 1'b1;
            end else if (rx_ovr_clr_i) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign rx_valid_o     = (r_count != '0);
    assign rx_data_o      = w_head.data;
    assign rx_frame_err_o = w_head.frame_err;
`ifdef UART_PARITY_EN
    assign rx_parity_err_o = w_head.parity_err;
`else
    assign rx_parity_err_o = 1'b0;
`endif
    assign rx_overrun_o   = r_ovr;
    assign rx_count_o     = r_count;

endmodule
